xm_exc_controller: RTL
======================

Name: xm_exc_controller

Overview:
- Multi-cycle exception/interrupt sequencer that works beside the main instruction controller.
- At instruction boundaries it takes a software trap or the highest-priority unmasked interrupt, pushes PC and PSW onto the stack, loads the handler address from the vector table, and clears GIE.
- On a return-from-exception instruction it pops PSW and PC.
- It drives the shared memory handshake and the SP/PC/PSW write ports, and holds excBusy_o high to stall the main controller while a sequence runs.

Parameters:
- WORD, 16, data/address width
- NUM_IRQ, 8, number of interrupt request lines (1..16)
- NUM_TRAP, 4, number of software trap vectors
- VEC_BASE, 16'hFFC0, byte address of vector table entry 0
- GIE_BIT, 4, bit index of global interrupt enable in PSW
- MEM_TIMEOUT, 255, busy-wait limit in cycles (used only with XM_EXC_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- instDone_i  in  1  one-cycle pulse at instruction boundary from main controller
- irq_i  in  NUM_IRQ  level interrupt requests; bit 0 is highest priority
- irqMask_i  in  NUM_IRQ  per-line enable (1 = enabled)
- trapReq_i  in  1  trap instruction decoded; qualified by instDone_i
- trapNum_i  in  $clog2(NUM_TRAP)  trap index
- retReq_i  in  1  return-from-exception decoded; qualified by instDone_i
- pcVal_i, spVal_i, pswVal_i  in  WORD  current PC/SP/PSW
- memBusy_i  in  1  memory busy
- memWr_i  in  1  read-data-valid strobe
- memRdData_i  in  WORD  read data
- memEn_o  out  1  one-cycle request pulse
- memRW_o  out  1  1 = write
- memAdr_o  out  WORD  byte address
- memWrData_o  out  WORD  write data
- pcWr_o, spWr_o, pswWr_o  out  1  register write strobes
- pcVal_o, spVal_o, pswVal_o  out  WORD  register write data
- irqAck_o  out  NUM_IRQ  one-hot acknowledge pulse
- excBusy_o  out  1  sequence in progress
- excFault_o  out  1  memory timeout fault pulse

Behaviour:
- Reset: state=IDLE. All outputs are 0 and internal latches are cleared. Reset mid-sequence aborts with no further memory or register writes.
- Acceptance happens only in IDLE with instDone_i=1. Priority is retReq_i > trapReq_i > IRQ.
- An IRQ is taken only when PSW[GIE_BIT]=1 and (irq_i & irqMask_i) != 0. The lowest set index wins.
- On IRQ accept, irqAck_o pulses that bit for one cycle.
- On accept, latch spVal_i into spReg, pcVal_i into pcReg, pswVal_i into pswReg, and the vector index: IRQ n gives n, trap t gives NUM_IRQ+t. excBusy_o rises the next cycle.
- A retReq_i arriving together with an IRQ runs the return first. The IRQ is re-evaluated at the next boundary.
- Entry sequence:
  - PUSH_PC: memEn_o=1, memRW_o=1, adr=spReg-2, data=pcReg. Then PUSH_PC_W.
  - PUSH_PC_W: wait while memBusy_i=1. Then PUSH_PSW.
  - PUSH_PSW: adr=spReg-4, data=pswReg. Then PUSH_PSW_W.
  - PUSH_PSW_W: wait while busy. Then VEC_RD.
  - VEC_RD: memEn_o=1, memRW_o=0, adr=VEC_BASE+2*idx. Then VEC_W.
  - VEC_W: wait for memWr_i=1 with memBusy_i=0. Then WRITEBACK.
- Entry WRITEBACK, a single cycle with all three strobes together:
  - pcWr_o, pcVal_o = read data
  - spWr_o, spVal_o = spReg-4
  - pswWr_o, pswVal_o = pswReg with GIE_BIT cleared
  - then IDLE
- Return sequence:
  - POP_PSW: read at spReg. Then POP_PSW_W, which latches data on memWr_i.
  - POP_PC: read at spReg+2. Then POP_PC_W.
  - WRITEBACK: pcVal_o=read PC, pswVal_o=read PSW (restored as read), spVal_o=spReg+4.
- Address arithmetic is modulo 2^WORD, so SP wrap-around (e.g. spReg=0x0002 gives 0x0000, 0xFFFE) is legal and not flagged.
- excBusy_o is 1 in every state except IDLE. A new request cannot be taken in the WRITEBACK cycle.
- Minimum latency from accept to handler PC write is 7 cycles with zero wait states. Each busy cycle adds one.
- memEn_o is never asserted in a wait state.

Optional Feature:
- Macro XM_EXC_TIMEOUT_EN.
- With it defined: a counter increments for each cycle a wait state sees memBusy_i=1 (or no memWr_i on reads). At MEM_TIMEOUT the block:
  - pulses excFault_o for one cycle
  - returns to IDLE
  - performs no register writes
- Without it: wait states wait indefinitely, and excFault_o is tied to 0.

Test Plan:
- Reset mid-sequence: reset asserted during PUSH_PSW_W -> next cycle IDLE, all outputs 0, no pcWr_o/spWr_o/pswWr_o.
- IRQ entry: SP=0x0400, PC=0x1234, PSW=0x0010, irq_i=0x0A, mask=0xFF, instDone_i -> irqAck_o=0x02; writes 0x1234 to 0x03FE and 0x0010 to 0x03FC; read at 0xFFC2 returns 0x8000 -> PC=0x8000, SP=0x03FC, PSW=0x0000 after 7 cycles.
- Trap with GIE off: PSW=0x0000, trapReq_i, trapNum_i=2, NUM_IRQ=8 -> vector read at 0xFFD4, irqAck_o stays 0.
- Return vs IRQ collision: retReq_i and irq_i=0x01 with SP=0x03FC, memory {0x03FC:0x0010, 0x03FE:0x1234} -> PSW=0x0010, PC=0x1234, SP=0x0400; IRQ taken on the following instDone_i.
- Wait states: memBusy_i held 3 cycles on each access -> entry completes in 16 cycles, one memEn_o pulse per access.
- Timeout (XM_EXC_TIMEOUT_EN, MEM_TIMEOUT=4): memBusy_i stuck at 1 in PUSH_PC_W -> excFault_o pulse after 4 cycles, IDLE, no register writes.

Source files
------------

// File: rtl/xm_exc_controller.sv
// ---------------------------------------------------------------------------
// xm_exc_controller
//
// Exception / interrupt sequencer working beside the main instruction
// controller. At an instruction boundary (instDone_i) it accepts, in priority
// order, a return-from-exception, a software trap or the lowest-numbered
// unmasked interrupt (only when PSW[GIE_BIT] is set).
//   Entry : push PC to SP-2, push PSW to SP-4, read vector at
//           VEC_BASE + 2*idx, then write PC=vector, SP=SP-4, PSW with GIE
//           cleared in one cycle.
//   Return: pop PSW from SP, pop PC from SP+2, then write PC, PSW (as read)
//           and SP=SP+4 in one cycle.
// excBusy_o is high in every state except IDLE and stalls the main controller.
//
// Memory handshake:
//   memEn_o is a one-cycle request pulse issued only from a request state,
//   never from a wait state. The following wait state holds while
//   memBusy_i=1. A write completes on the first wait cycle with memBusy_i=0;
//   a read completes on the first wait cycle with memWr_i=1 and memBusy_i=0,
//   where memRdData_i is captured.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instDone_i                   instruction boundary pulse
//   irq_i, irqMask_i             level requests and per-line enables
//   trapReq_i, trapNum_i         trap request and trap index
//   retReq_i                     return-from-exception request
//   pcVal_i, spVal_i, pswVal_i   current architectural registers
//   memBusy_i, memWr_i,
//   memRdData_i                  memory busy, read-data-valid, read data
//   memEn_o, memRW_o, memAdr_o,
//   memWrData_o                  memory request (memRW_o=1 is a write)
//   pcWr_o/spWr_o/pswWr_o and
//   pcVal_o/spVal_o/pswVal_o     register write strobes and data
//   irqAck_o                     one-hot acknowledge pulse
//   excBusy_o                    sequence in progress
//   excFault_o                   memory timeout fault pulse
//
// Optional build macro XM_EXC_TIMEOUT_EN: wait states give up after
// MEM_TIMEOUT stalled cycles, pulse excFault_o and return to IDLE without
// register writes. Without it wait states wait forever and excFault_o is 0.
// All outputs are registered: each is computed for the state being entered.
// ---------------------------------------------------------------------------
module xm_exc_controller #(
  parameter int              WORD        = 16,
  parameter int              NUM_IRQ     = 8,
  parameter int              NUM_TRAP    = 4,
  parameter logic [WORD-1:0] VEC_BASE    = 16'hFFC0,
  parameter int              GIE_BIT     = 4,
  parameter int              MEM_TIMEOUT = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instDone_i,
  input  logic [NUM_IRQ-1:0]          irq_i,
  input  logic [NUM_IRQ-1:0]          irqMask_i,
  input  logic                        trapReq_i,
  input  logic [$clog2(NUM_TRAP)-1:0] trapNum_i,
  input  logic                        retReq_i,
  input  logic [WORD-1:0]             pcVal_i,
  input  logic [WORD-1:0]             spVal_i,
  input  logic [WORD-1:0]             pswVal_i,
  input  logic                        memBusy_i,
  input  logic                        memWr_i,
  input  logic [WORD-1:0]             memRdData_i,
  output logic                        memEn_o,
  output logic                        memRW_o,
  output logic [WORD-1:0]             memAdr_o,
  output logic [WORD-1:0]             memWrData_o,
  output logic                        pcWr_o,
  output logic                        spWr_o,
  output logic                        pswWr_o,
  output logic [WORD-1:0]             pcVal_o,
  output logic [WORD-1:0]             spVal_o,
  output logic [WORD-1:0]             pswVal_o,
  output logic [NUM_IRQ-1:0]          irqAck_o,
  output logic                        excBusy_o,
  output logic                        excFault_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_PC_W,
    S_PUSH_PSW,
    S_PUSH_PSW_W,
    S_VEC_RD,
    S_VEC_W,
    S_POP_PSW,
    S_POP_PSW_W,
    S_POP_PC,
    S_POP_PC_W,
    S_WRITEBACK
  } state_t;

  localparam logic [WORD-1:0] GIE_MASK = WORD'(1) << GIE_BIT;
  localparam logic [WORD-1:0] TWO      = WORD'(2);
  localparam logic [WORD-1:0] FOUR     = WORD'(4);

  state_t state_q, state_d;

  // Latched context for the running sequence.
  logic [WORD-1:0] sp_q, sp_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] psw_q, psw_d;     // pushed PSW on entry, popped PSW on return
  logic [WORD-1:0] idx_q, idx_d;     // vector index
  logic            ret_q, ret_d;     // 1 = return sequence

  // Registered outputs.
  logic               mem_en_q, mem_en_d;
  logic               mem_rw_q, mem_rw_d;
  logic [WORD-1:0]    mem_adr_q, mem_adr_d;
  logic [WORD-1:0]    mem_wdata_q, mem_wdata_d;
  logic               pc_wr_q, pc_wr_d;
  logic               sp_wr_q, sp_wr_d;
  logic               psw_wr_q, psw_wr_d;
  logic [WORD-1:0]    pc_val_q, pc_val_d;
  logic [WORD-1:0]    sp_val_q, sp_val_d;
  logic [WORD-1:0]    psw_val_q, psw_val_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;

  // A wait state that did not complete this cycle.
  logic wait_stall;

  // Interrupt priority encoder: lowest pending index wins.
  logic [NUM_IRQ-1:0] irq_pend;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [WORD-1:0]    irq_num;
  logic               irq_hit;

  assign irq_pend = irq_i & irqMask_i;

  always_comb begin
    irq_hit    = 1'b0;
    irq_onehot = '0;
    irq_num    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_hit       = 1'b1;
        irq_onehot    = '0;
        irq_onehot[i] = 1'b1;
        irq_num       = WORD'(i);
      end
    end
  end

`ifdef XM_EXC_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`else
  logic unused_cfg;
  assign unused_cfg = wait_stall ^ (MEM_TIMEOUT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    pc_d       = pc_q;
    psw_d      = psw_q;
    idx_d      = idx_q;
    ret_d      = ret_q;
    ack_d      = '0;
    wait_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instDone_i) begin
          if (retReq_i) begin
            ret_d   = 1'b1;
            sp_d    = spVal_i;
            pc_d    = pcVal_i;
            psw_d   = pswVal_i;
            state_d = S_POP_PSW;
          end else if (trapReq_i) begin
            ret_d   = 1'b0;
            sp_d    = spVal_i;
            pc_d    = pcVal_i;
            psw_d   = pswVal_i;
            idx_d   = WORD'(NUM_IRQ) + WORD'(trapNum_i);
            state_d = S_PUSH_PC;
          end else if (pswVal_i[GIE_BIT] && irq_hit) begin
            ret_d   = 1'b0;
            sp_d    = spVal_i;
            pc_d    = pcVal_i;
            psw_d   = pswVal_i;
            idx_d   = irq_num;
            ack_d   = irq_onehot;
            state_d = S_PUSH_PC;
          end
        end
      end
      S_PUSH_PC:  state_d = S_PUSH_PC_W;
      S_PUSH_PC_W: begin
        if (memBusy_i) wait_stall = 1'b1;
        else           state_d    = S_PUSH_PSW;
      end
      S_PUSH_PSW: state_d = S_PUSH_PSW_W;
      S_PUSH_PSW_W: begin
        if (memBusy_i) wait_stall = 1'b1;
        else           state_d    = S_VEC_RD;
      end
      S_VEC_RD:   state_d = S_VEC_W;
      S_VEC_W: begin
        if (memWr_i && !memBusy_i) state_d    = S_WRITEBACK;
        else                       wait_stall = 1'b1;
      end
      S_POP_PSW:  state_d = S_POP_PSW_W;
      S_POP_PSW_W: begin
        if (memWr_i && !memBusy_i) begin
          psw_d   = memRdData_i;
          state_d = S_POP_PC;
        end else begin
          wait_stall = 1'b1;
        end
      end
      S_POP_PC:   state_d = S_POP_PC_W;
      S_POP_PC_W: begin
        if (memWr_i && !memBusy_i) state_d    = S_WRITEBACK;
        else                       wait_stall = 1'b1;
      end
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

`ifdef XM_EXC_TIMEOUT_EN
    cnt_d   = '0;
    fault_d = 1'b0;
    if (wait_stall) begin
      if (cnt_q >= CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_IDLE;
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    // Outputs for the state being entered.
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_adr_d   = '0;
    mem_wdata_d = '0;
    pc_wr_d     = 1'b0;
    sp_wr_d     = 1'b0;
    psw_wr_d    = 1'b0;
    pc_val_d    = '0;
    sp_val_d    = '0;
    psw_val_d   = '0;
    busy_d      = (state_d != S_IDLE);

    case (state_d)
      S_PUSH_PC: begin
        mem_en_d    = 1'b1;
        mem_rw_d    = 1'b1;
        mem_adr_d   = sp_d - TWO;
        mem_wdata_d = pc_d;
      end
      S_PUSH_PSW: begin
        mem_en_d    = 1'b1;
        mem_rw_d    = 1'b1;
        mem_adr_d   = sp_d - FOUR;
        mem_wdata_d = psw_d;
      end
      S_VEC_RD: begin
        mem_en_d  = 1'b1;
        mem_adr_d = VEC_BASE + (idx_d << 1);
      end
      S_POP_PSW: begin
        mem_en_d  = 1'b1;
        mem_adr_d = sp_d;
      end
      S_POP_PC: begin
        mem_en_d  = 1'b1;
        mem_adr_d = sp_d + TWO;
      end
      S_WRITEBACK: begin
        // Entered only from a completing read, so memRdData_i is the new PC.
        pc_wr_d  = 1'b1;
        sp_wr_d  = 1'b1;
        psw_wr_d = 1'b1;
        pc_val_d = memRdData_i;
        if (ret_d) begin
          sp_val_d  = sp_d + FOUR;
          psw_val_d = psw_d;
        end else begin
          sp_val_d  = sp_d - FOUR;
          psw_val_d = psw_d & ~GIE_MASK;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      pc_q        <= '0;
      psw_q       <= '0;
      idx_q       <= '0;
      ret_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      pc_wr_q     <= 1'b0;
      sp_wr_q     <= 1'b0;
      psw_wr_q    <= 1'b0;
      pc_val_q    <= '0;
      sp_val_q    <= '0;
      psw_val_q   <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
`ifdef XM_EXC_TIMEOUT_EN
      cnt_q       <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pc_q        <= pc_d;
      psw_q       <= psw_d;
      idx_q       <= idx_d;
      ret_q       <= ret_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_wr_q     <= pc_wr_d;
      sp_wr_q     <= sp_wr_d;
      psw_wr_q    <= psw_wr_d;
      pc_val_q    <= pc_val_d;
      sp_val_q    <= sp_val_d;
      psw_val_q   <= psw_val_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
`ifdef XM_EXC_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign memEn_o     = mem_en_q;
  assign memRW_o     = mem_rw_q;
  assign memAdr_o    = mem_adr_q;
  assign memWrData_o = mem_wdata_q;
  assign pcWr_o      = pc_wr_q;
  assign spWr_o      = sp_wr_q;
  assign pswWr_o     = psw_wr_q;
  assign pcVal_o     = pc_val_q;
  assign spVal_o     = sp_val_q;
  assign pswVal_o    = psw_val_q;
  assign irqAck_o    = ack_q;
  assign excBusy_o   = busy_q;
`ifdef XM_EXC_TIMEOUT_EN
  assign excFault_o  = fault_q;
`else
  assign excFault_o  = 1'b0;
`endif

endmodule
